// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: four-state controller (IDLE/READ/EXEC/WRITE) that runs one
// register-to-register instruction at a time against an 8x16 register file.
module rf_op_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [2:0]        rf_rd0_addr,
  output logic [2:0]        rf_rd1_addr,
  input  logic [DATA_W-1:0] rf_rd0_data,
  input  logic [DATA_W-1:0] rf_rd1_data,
  output logic              rf_wr_en,
  output logic [2:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              done,
  output logic              zero,
  output logic              carry,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned SH_W    = 4;
  localparam int unsigned IMM_W   = 10;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [OP_W-1:0] OP_LDI = 3'd6;
  localparam logic [OP_W-1:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic                res_carry_q, res_carry_d;
  logic                res_zero_q, res_zero_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   rd0_addr_q, rd0_addr_d;
  logic [ADDR_W-1:0]   rd1_addr_q, rd1_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Field decode of the latched instruction
  logic [OP_W-1:0]   op_f;
  logic [ADDR_W-1:0] rd_f;
  logic [SH_W-1:0]   sh_f;
  logic [IMM_W-1:0]  imm_f;

  assign op_f  = instr_q[15:13];
  assign rd_f  = instr_q[12:10];
  assign sh_f  = instr_q[3:0];
  assign imm_f = instr_q[9:0];

  // ALU: combinational result and carry from the operand registers
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  assign sum_w = {1'b0, op_a_q} + {1'b0, op_b_q};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_f)
      OP_ADD: begin
        alu_res   = sum_w[DATA_W-1:0];
        alu_carry = sum_w[DATA_W];
      end
      OP_SUB: begin
        alu_res   = op_a_q - op_b_q;
        alu_carry = (op_a_q < op_b_q);
      end
      OP_AND:  alu_res = op_a_q & op_b_q;
      OP_OR:   alu_res = op_a_q | op_b_q;
      OP_XOR:  alu_res = op_a_q ^ op_b_q;
      OP_LDI:  alu_res = {{(DATA_W-IMM_W){imm_f[IMM_W-1]}}, imm_f};
      OP_SHL:  alu_res = op_a_q << sh_f;
      default: alu_res = '0;
    endcase
  end

  // Next-state and next-output logic; registered outputs follow the next state
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    ready_d     = 1'b0;
    rd0_addr_d  = '0;
    rd1_addr_d  = '0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    zero_d      = zero_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d    = instr;
          rd0_addr_d = instr[9:7];
          rd1_addr_d = instr[6:4];
          state_d    = S_READ;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_READ: begin
        op_a_d  = rf_rd0_data;
        op_b_d  = rf_rd1_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wr_data_d   = alu_res;
        wr_addr_d   = rd_f;
        res_carry_d = alu_carry;
        res_zero_d  = (alu_res == '0);
        wr_en_d     = (op_f != OP_NOP);
        done_d      = 1'b1;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        if (op_f != OP_NOP) begin
          zero_d  = res_zero_q;
          carry_d = res_carry_q;
        end
        cnt_d   = cnt_q + CNT_W'(1);
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      ready_q     <= 1'b1;
      rd0_addr_q  <= '0;
      rd1_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      ready_q     <= ready_d;
      rd0_addr_q  <= rd0_addr_d;
      rd1_addr_q  <= rd1_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
    end
  end

  assign instr_ready = ready_q;
  assign rf_rd0_addr = rd0_addr_q;
  assign rf_rd1_addr = rd1_addr_q;
  // Write enable is gated by rst so a reset cycle can never commit a write
  assign rf_wr_en    = wr_en_q & ~rst;
  assign rf_wr_addr  = wr_addr_q;
  assign rf_wr_data  = wr_data_q;
  assign done        = done_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign retired_cnt = cnt_q;

endmodule

// File: doc/rf_op_sequencer.md
Name: rf_op_sequencer

Overview:
- Multi-cycle controller that executes one register-to-register operation at a time on the 8x16 register file.
- Accepts a 16-bit instruction over a valid/ready handshake and drives the file's read addresses.
- Computes the result in an internal ALU and drives the single write port for exactly one cycle.
- Sits between the instruction source (test driver or a future fetch unit) and the register file; it is the register file's only writer.

Parameters:
- DATA_W, 16, register and ALU data width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction available
- instr  input  16  instruction word
- instr_ready  output  1  sequencer can accept an instruction
- rf_rd0_addr  output  3  register file read port 0 address
- rf_rd1_addr  output  3  register file read port 1 address
- rf_rd0_data  input  DATA_W  register file read port 0 data (combinational read)
- rf_rd1_data  input  DATA_W  register file read port 1 data (combinational read)
- rf_wr_en  output  1  register file write enable
- rf_wr_addr  output  3  register file write address
- rf_wr_data  output  DATA_W  register file write data
- done  output  1  one-cycle pulse when an instruction retires
- zero  output  1  last retired result == 0
- carry  output  1  carry/borrow from the last retired ADD/SUB
- retired_cnt  output  CNT_W  count of retired instructions

Behaviour:
- Instruction fields: op=[15:13], rd=[12:10], rs0=[9:7], rs1=[6:4], sh=[3:0], imm10=[9:0].
- Opcodes:
  - 000 NOP: no write.
  - 001 ADD: rd=rs0+rs1.
  - 010 SUB: rd=rs0-rs1.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 LDI: rd=sign-extend(imm10).
  - 111 SHL: rd=rs0<<sh, with zero fill.
- Arithmetic: results truncated to DATA_W. carry = bit DATA_W of the (DATA_W+1)-bit sum for ADD. For SUB, carry = 1 when rs0<rs1 (unsigned borrow).
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE: instr_ready=1. When instr_valid && instr_ready, latch instr and go to READ. Otherwise stay in IDLE.
  - READ: rf_rd0_addr=rs0, rf_rd1_addr=rs1. Capture rf_rd0_data/rf_rd1_data into operand registers at the end of the cycle. Go to EXEC.
  - EXEC: ALU computes from the operand registers. Result, carry and zero are registered at the end of the cycle. Go to WRITE.
  - WRITE: rf_wr_en=1 unless op=NOP; rf_wr_addr=rd; rf_wr_data=result. done=1. retired_cnt increments (NOP included). zero/carry outputs update at the end of this cycle. Go to IDLE.
- Latency and throughput:
  - Handshake at edge E0; READ in cycle 1, EXEC in cycle 2, WRITE in cycle 3.
  - The register write commits at the edge ending cycle 3.
  - instr_ready is high again in cycle 4.
  - Throughput is one instruction per 4 cycles.
- Handshake rules:
  - instr_ready is low in READ, EXEC and WRITE.
  - instr_valid while not ready is ignored; the source must hold the instruction.
  - instr is sampled only on the accepting edge; later changes have no effect on the instruction in flight.
- Flags:
  - zero/carry are unchanged by NOP.
  - Logic ops, LDI and SHL clear carry.
  - zero is updated by every non-NOP instruction.
- Read-after-write: the write commits before the next READ, so a dependent back-to-back instruction sees the new value. No forwarding is needed.
- Address outputs:
  - In IDLE, rf_rd0_addr/rf_rd1_addr = 0.
  - Outside WRITE, rf_wr_addr/rf_wr_data hold their last values.
  - rf_wr_en is low in every state except WRITE.
- retired_cnt wraps from 2^CNT_W-1 to 0.
- Reset values (rst=1 at a clock edge): state=IDLE; instr_ready=1 in the following cycle; rf_wr_en=0, done=0, zero=0, carry=0, retired_cnt=0; rf_rd0_addr=rf_rd1_addr=rf_wr_addr=0; rf_wr_data=0; operand/result registers=0.
- Reset mid-operation: rst asserted in any state returns to IDLE. An instruction in READ/EXEC/WRITE is dropped. No write occurs in the reset cycle, since rf_wr_en is forced low while rst=1.
- The register file's own contents are cleared by the shared rst.
- rst takes priority over instr_valid.

Test Plan:
- Reset, then LDI r1,5 (0xC405) -> instr_ready low for 3 cycles; rf_wr_en=1 addr 1 data 0x0005 in cycle 3; done pulse; retired_cnt=1.
- LDI r1,0x3FF (-1), LDI r2,1, ADD r3,r1,r2 -> r3 write data 0x0000, zero=1, carry=1; issued back-to-back, total 12 cycles.
- LDI r4,3; LDI r5,7; SUB r6,r4,r5 -> data 0xFFFC, carry=1 (borrow), zero=0; then XOR r7,r6,r6 -> 0x0000, zero=1, carry=0.
- SHL r2,r1 by 4 with r1=0x8001 (SHL r2 from r1 with rs1 field 0 and sh=4, or any rs1 value, since SHL ignores rs1) -> 0x0010. NOP -> no rf_wr_en, done pulse, flags unchanged, retired_cnt increments.
- instr_valid held high with changing instr while busy -> only the instruction present on the accepting edge executes; the others are ignored until instr_ready returns.
- rst asserted during EXEC of ADD r3 -> no write to r3 at any point, state IDLE, retired_cnt=0. Next accepted instruction executes normally.
